// File: rtl/wb_pkg.sv
// ------------------------------------------------------------------
// wb_pkg: opcodes, FSM state type and shared decode helpers for WB.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_MOV  = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_STR  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNEQ = 6'd5;
  localparam logic [5:0] OP_ALU  = 6'd6;
  localparam logic [5:0] OP_LDI  = 6'd7;
  localparam logic [5:0] OP_STRI = 6'd8;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_LD = 1'b1
  } wb_state_t;

  // True for every opcode that eventually writes the register file, loads included.
  function automatic logic is_reg_write(input logic [5:0] op);
    return (op == OP_MOV) || (op == OP_LD) || (op == OP_ALU) || (op == OP_LDI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_decode.sv
// ------------------------------------------------------------------
// wb_decode: combinational opcode and destination decoder for WB.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_decode
  import wb_pkg::*;
#(
  parameter int IR_W  = 64,
  parameter int RA_W  = 6,
  parameter int RD_LO = 12
) (
  input  logic [IR_W-1:0] ir,
  output logic [5:0]      opcode,
  output logic            writes_reg,
  output logic            is_load,
  output logic            is_store,
  output logic            illegal,
  output logic [RA_W-1:0] dest
);

  // Only a few fields of the word matter here.
  logic unused_ir;
  assign unused_ir = ^ir;

  always_comb begin
    opcode     = ir[IR_W-1 -: 6];
    is_load    = (opcode == OP_LD);
    writes_reg = is_reg_write(opcode) && !is_load;
    is_store   = (opcode == OP_STR) || (opcode == OP_STRI);
    illegal    = (opcode > OP_STRI);
    dest       = (opcode == OP_LDI) ? ir[IR_W-7 -: RA_W] : ir[RD_LO +: RA_W];
  end

endmodule

`default_nettype wire

// File: rtl/wb_ctrl_stage.sv
// ------------------------------------------------------------------
// wb_ctrl_stage: registered write-back controller with load stall.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_ctrl_stage
  import wb_pkg::*;
#(
  parameter int IR_W        = 64,
  parameter int DATA_W      = 64,
  parameter int RA_W        = 6,
  parameter int RD_LO       = 12,
  parameter int LD_TIMEOUT  = 15,
  parameter int ZERO_REG_RO = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_we,
  output logic              illegal_op,
  output logic              ld_timeout,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int TO_W = $clog2(LD_TIMEOUT + 1);

  wb_state_t         state, state_next;
  logic [TO_W-1:0]   to_cnt;
  logic [RA_W-1:0]   ld_dest;

  logic [5:0]        opcode;
  logic              writes_reg, is_load, is_store, illegal;
  logic [RA_W-1:0]   dest;

  logic              accept;
  logic              do_write, store_pulse, retire, set_illegal, set_timeout;
  logic              load_start, to_inc;
  logic [RA_W-1:0]   write_addr;
  logic [DATA_W-1:0] write_data;

  wb_decode #(
    .IR_W  (IR_W),
    .RA_W  (RA_W),
    .RD_LO (RD_LO)
  ) u_decode (
    .ir         (in_ir),
    .opcode     (opcode),
    .writes_reg (writes_reg),
    .is_load    (is_load),
    .is_store   (is_store),
    .illegal    (illegal),
    .dest       (dest)
  );

  function automatic logic dest_writable(input logic [RA_W-1:0] d);
    return (ZERO_REG_RO == 0) || (d != '0);
  endfunction

  assign in_ready = rst_n && (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next  = state;
    do_write    = 1'b0;
    write_addr  = ld_dest;
    write_data  = mem_rdata;
    store_pulse = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    load_start  = 1'b0;
    to_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_load) begin
            state_next = ST_WAIT_LD;
            load_start = 1'b1;
          end else begin
            write_addr  = dest;
            write_data  = in_alu_result;
            do_write    = writes_reg && dest_writable(dest);
            store_pulse = is_store;
            set_illegal = illegal;
            retire      = !illegal && (opcode != OP_NOP);
          end
        end
      end
      ST_WAIT_LD: begin
        // Data arriving on the last allowed cycle beats the timeout.
        if (mem_rvalid) begin
          do_write   = dest_writable(ld_dest);
          retire     = 1'b1;
          state_next = ST_IDLE;
        end else if (to_cnt == TO_W'(LD_TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      ld_dest    <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      mem_we     <= 1'b0;
      illegal_op <= 1'b0;
      ld_timeout <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state  <= state_next;
      rf_we  <= do_write;
      mem_we <= store_pulse;
      if (do_write) begin
        rf_waddr <= write_addr;
        rf_wdata <= write_data;
      end
      if (set_illegal) illegal_op <= 1'b1;
      if (set_timeout) ld_timeout <= 1'b1;
      if (retire)      retire_cnt <= retire_cnt + CNT_W'(1);
      if (load_start) begin
        ld_dest <= dest;
        to_cnt  <= '0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_ctrl_stage.sv
// ------------------------------------------------------------------
// tb_wb_ctrl_stage: directed and random checks of wb_ctrl_stage.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_wb_ctrl_stage;

  localparam int IR_W = 64, DATA_W = 64, RA_W = 6, RD_LO = 12;
  localparam int LD_TIMEOUT = 15, ZERO_REG_RO = 1, CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IR_W-1:0]   in_ir = '0;
  logic [DATA_W-1:0] in_alu_result = '0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_we;
  logic              illegal_op;
  logic              ld_timeout;
  logic [CNT_W-1:0]  retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic              m_busy = 1'b0;
  int                m_waited = 0;
  logic [RA_W-1:0]   m_ld_dest = '0;
  logic              m_we = 1'b0, m_mwe = 1'b0, m_illegal = 1'b0, m_tmo = 1'b0;
  logic [RA_W-1:0]   m_waddr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [CNT_W-1:0]  m_cnt = '0;

  wb_ctrl_stage #(
    .IR_W (IR_W), .DATA_W (DATA_W), .RA_W (RA_W), .RD_LO (RD_LO),
    .LD_TIMEOUT (LD_TIMEOUT), .ZERO_REG_RO (ZERO_REG_RO), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_ir (in_ir), .in_alu_result (in_alu_result), .mem_rvalid (mem_rvalid),
    .mem_rdata (mem_rdata), .rf_we (rf_we), .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata), .mem_we (mem_we), .illegal_op (illegal_op),
    .ld_timeout (ld_timeout), .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [IR_W-1:0] mk_ir(input logic [5:0] op, input logic [5:0] rd,
                                            input logic [5:0] ldi_rd);
    logic [IR_W-1:0] w;
    w = {$urandom, $urandom};
    w[63:58] = op;
    w[57:52] = ldi_rd;
    w[17:12] = rd;
    return w;
  endfunction

  task automatic model_write(input logic [RA_W-1:0] d, input logic [DATA_W-1:0] data);
    if (!(ZERO_REG_RO != 0 && d == '0)) begin
      m_we    = 1'b1;
      m_waddr = d;
      m_wdata = data;
    end
  endtask

  // One clock: drive inputs, check in_ready, predict, step, check registered outputs.
  task automatic cycle(input logic rst, input logic v, input logic [IR_W-1:0] ir,
                       input logic [DATA_W-1:0] alu, input logic rv,
                       input logic [DATA_W-1:0] rd);
    logic [5:0] op;
    logic [5:0] dst;
    rst_n = rst; in_valid = v; in_ir = ir; in_alu_result = alu;
    mem_rvalid = rv; mem_rdata = rd;
    #1;
    check("in_ready", 64'(in_ready), 64'(rst && !m_busy));
    m_we = 1'b0;
    m_mwe = 1'b0;
    if (!rst) begin
      m_busy = 1'b0; m_waited = 0; m_illegal = 1'b0; m_tmo = 1'b0;
      m_cnt = '0; m_waddr = '0; m_wdata = '0;
    end else if (m_busy) begin
      m_waited++;
      if (rv) begin
        model_write(m_ld_dest, rd);
        m_cnt++;
        m_busy = 1'b0;
      end else if (m_waited >= LD_TIMEOUT) begin
        m_tmo  = 1'b1;
        m_busy = 1'b0;
      end
    end else if (v) begin
      op  = ir[63:58];
      dst = (op == 6'd7) ? ir[57:52] : ir[17:12];
      case (op)
        6'd0:             ;
        6'd1, 6'd6, 6'd7: begin model_write(dst, alu); m_cnt++; end
        6'd2:             begin m_busy = 1'b1; m_waited = 0; m_ld_dest = dst; end
        6'd3, 6'd8:       begin m_mwe = 1'b1; m_cnt++; end
        6'd4, 6'd5:       m_cnt++;
        default:          m_illegal = 1'b1;
      endcase
    end
    @(posedge clk);
    #1;
    check("rf_we",      64'(rf_we),      64'(m_we));
    check("mem_we",     64'(mem_we),     64'(m_mwe));
    check("rf_waddr",   64'(rf_waddr),   64'(m_waddr));
    check("rf_wdata",   rf_wdata,        m_wdata);
    check("illegal_op", 64'(illegal_op), 64'(m_illegal));
    check("ld_timeout", 64'(ld_timeout), 64'(m_tmo));
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [IR_W-1:0] ir;
    int r;

    do_reset();
    check("rst_retire", 64'(retire_cnt), 64'd0);

    // ALU to r5
    cycle(1'b1, 1'b1, mk_ir(6'd6, 6'd5, 6'd0), 64'hDEAD_BEEF, 1'b0, '0);
    check("alu_waddr", 64'(rf_waddr), 64'd5);
    check("alu_wdata", rf_wdata, 64'hDEAD_BEEF);
    check("alu_retire", 64'(retire_cnt), 64'd1);

    // LDI uses the upper destination field
    cycle(1'b1, 1'b1, mk_ir(6'd7, 6'd3, 6'd9), 64'h55, 1'b0, '0);
    check("ldi_waddr", 64'(rf_waddr), 64'd9);

    // LD to r7, data in the 4th wait cycle, then back-to-back MOV
    cycle(1'b1, 1'b1, mk_ir(6'd2, 6'd7, 6'd0), '0, 1'b0, '0);
    cycle(1'b1, 1'b1, mk_ir(6'd1, 6'd2, 6'd0), 64'h99, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 64'h1234);
    check("ld_wdata", rf_wdata, 64'h1234);
    cycle(1'b1, 1'b1, mk_ir(6'd1, 6'd4, 6'd0), 64'hAA, 1'b0, '0);
    cycle(1'b1, 1'b1, mk_ir(6'd1, 6'd6, 6'd0), 64'hBB, 1'b0, '0);

    // Timeout with no data
    cycle(1'b1, 1'b1, mk_ir(6'd2, 6'd8, 6'd0), '0, 1'b0, '0);
    idle(LD_TIMEOUT);
    check("tmo_flag", 64'(ld_timeout), 64'd1);
    idle(2);
    do_reset();

    // Data on the timeout cycle wins
    cycle(1'b1, 1'b1, mk_ir(6'd2, 6'd10, 6'd0), '0, 1'b0, '0);
    idle(LD_TIMEOUT - 1);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 64'hCAFE);
    check("tmo_race_flag", 64'(ld_timeout), 64'd0);
    check("tmo_race_we", 64'(rf_we), 64'd1);

    // STR, STRI back-to-back, then illegal
    cycle(1'b1, 1'b1, mk_ir(6'd3, 6'd1, 6'd0), '0, 1'b0, '0);
    cycle(1'b1, 1'b1, mk_ir(6'd8, 6'd1, 6'd0), '0, 1'b0, '0);
    cycle(1'b1, 1'b1, mk_ir(6'h3F, 6'd1, 6'd0), 64'h77, 1'b0, '0);
    check("illegal_flag", 64'(illegal_op), 64'd1);
    cycle(1'b1, 1'b1, mk_ir(6'd0, 6'd1, 6'd0), 64'h77, 1'b1, 64'h1);

    // Write to r0 suppressed but retired
    cycle(1'b1, 1'b1, mk_ir(6'd1, 6'd0, 6'd0), 64'h42, 1'b0, '0);
    check("r0_we", 64'(rf_we), 64'd0);

    // Reset while waiting for a load; late data ignored
    cycle(1'b1, 1'b1, mk_ir(6'd2, 6'd11, 6'd0), '0, 1'b0, '0);
    idle(3);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 64'hBAD);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 64'hBAD);
    check("late_rvalid_we", 64'(rf_we), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)
        ir = mk_ir(6'($urandom_range(9, 63)), 6'($urandom), 6'($urandom));
      else
        ir = mk_ir(6'($urandom_range(0, 8)),
                   ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom),
                   ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom));
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 4) != 0), ir,
            {$urandom, $urandom}, ($urandom_range(0, 6) == 0), {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
